// File: rtl/program_loader_pkg.sv
// program_loader_pkg
// Shared definitions for the program loader: FSM state encoding, the
// fixed number of bytes per memory word, and default memory port widths
// matching the multicycle MIPS core's instruction/data memory.
// Ports: none (package).
// Configuration: PROG_LOADER_CHECKSUM_EN (see program_loader.sv) makes the
// CHK state reachable; the encoding always contains it.

package program_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int MEM_ADDR_W     = 8;
  localparam int MEM_DATA_W     = 32;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    WRITE,
    CHK,
    DONE
  } state_t;

endpackage

// File: rtl/loader_word_assembler.sv
// loader_word_assembler
// Collects stream bytes MSB first into one memory word. The first byte of
// a word ends up in the top byte once four bytes have been shifted in.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : restart assembly (word and byte index back to zero)
//   shift_en    : a byte is being accepted this cycle
//   byte_in     : the byte being accepted
//   word        : assembled word (valid after word_full)
//   word_full   : this cycle's byte completes the word

module loader_word_assembler
  import program_loader_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_full
);

  logic [1:0] idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word <= '0;
      idx  <= 2'd0;
    end else if (clear) begin
      word <= '0;
      idx  <= 2'd0;
    end else if (shift_en) begin
      word <= {word[DATA_W-9:0], byte_in};
      idx  <= idx + 2'd1;
    end
  end

  // The 2-bit index wraps to zero by itself after the fourth byte.
  assign word_full = shift_en && (idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// program_loader
// Fills the core's instruction/data memory from a byte stream before the
// core runs. The first byte is the word count N (0 means 256), followed by
// 4N data bytes assembled big-endian and written at consecutive word
// addresses starting at BASE_ADDR (wrapping modulo 2^ADDR_W). The core is
// held in reset through cpu_rst_n until a load completes.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   load_start            : request a new load (honoured in IDLE or DONE)
//   in_valid/in_byte      : byte stream, consumed when in_valid && in_ready
//   in_ready              : loader accepts a byte this cycle
//   mem_we/mem_addr/mem_din : memory write port (wea/addra/dina)
//   busy                  : load in progress, selects loader onto memory
//   done                  : one-cycle pulse on successful completion
//   err                   : sticky checksum error, cleared by load_start
//   cpu_rst_n             : active-low reset to the core
// Configuration: define PROG_LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte over all data bytes after the last word.

module program_loader
  import program_loader_pkg::*;
#(
  parameter int                ADDR_W    = MEM_ADDR_W,
  parameter int                DATA_W    = MEM_DATA_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(0)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              cpu_rst_n
);

  state_t            state, state_nxt;
  logic              xfer;
  logic              start_ok;
  logic              shift_en;
  logic              word_full;
  logic              last_word;
  logic              err_set;
  logic [7:0]        n_q;
  logic [7:0]        word_cnt;
  logic [7:0]        cnt_inc;
  logic              run_q;
  logic              err_q;
  logic [DATA_W-1:0] word;

  // A new load is only honoured when no load is running.
  assign start_ok = load_start && ((state == IDLE) || (state == DONE));
  assign xfer     = in_valid && in_ready;
  assign shift_en = xfer && (state == DATA);

  // 8-bit compare lets N=0 mean 256: the counter reaches 255 and 255+1 wraps to 0.
  assign cnt_inc   = word_cnt + 8'd1;
  assign last_word = (cnt_inc == n_q);

  loader_word_assembler #(
    .DATA_W(DATA_W)
  ) u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (start_ok),
    .shift_en (shift_en),
    .byte_in  (in_byte),
    .word     (word),
    .word_full(word_full)
  );

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0] chk_q;
  logic       chk_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_q <= 8'h00;
    end else if (start_ok) begin
      chk_q <= 8'h00;
    end else if (shift_en) begin
      chk_q <= chk_q ^ in_byte;
    end
  end

  assign chk_ok = (in_byte == chk_q);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    err_set   = 1'b0;
    in_ready  = 1'b0;
    mem_we    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) state_nxt = LEN;
      end
      LEN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) state_nxt = DATA;
      end
      DATA: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (word_full) state_nxt = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        busy   = 1'b1;
        if (last_word) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_nxt = CHK;
`else
          state_nxt = DONE;
`endif
        end else begin
          state_nxt = DATA;
        end
      end
      CHK: begin
`ifdef PROG_LOADER_CHECKSUM_EN
        in_ready = 1'b1;
        busy     = 1'b1;
        if (xfer) begin
          if (chk_ok) begin
            state_nxt = DONE;
          end else begin
            state_nxt = IDLE;
            err_set   = 1'b1;
          end
        end
`else
        state_nxt = IDLE;
`endif
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start_ok ? LEN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Load length, word counter, core-run flag and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q      <= 8'h00;
      word_cnt <= 8'h00;
      run_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (state == LEN && xfer) n_q <= in_byte;
      if (start_ok) begin
        word_cnt <= 8'h00;
        run_q    <= 1'b0;
        err_q    <= 1'b0;
      end else begin
        if (state == WRITE) word_cnt <= cnt_inc;
        if (state == DONE) run_q <= 1'b1;
        if (err_set) err_q <= 1'b1;
      end
    end
  end

  assign mem_addr  = BASE_ADDR + ADDR_W'(word_cnt);
  assign mem_din   = (state == WRITE) ? word : '0;
  assign err       = err_q;
  // run_q only rises after DONE, so DONE itself releases the core directly.
  assign cpu_rst_n = run_q || (state == DONE);

endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader
// Two loader instances (base 8'h00 and base 8'hFE) share the byte stream;
// cur_sel routes in_valid/load_start to one of them. Expected memory writes
// are queued when a load is driven and popped by a monitor on mem_we.
// PROG_LOADER_CHECKSUM_EN must match the RTL build.

module tb_program_loader;

  typedef struct {
    int          sel;
    logic [7:0]  n_byte;
    logic [31:0] w0;
    logic [31:0] w1;
    bit          stall;
    bit          poke;
  } load_vec_t;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [7:0]  in_byte;
  logic        load_start0, load_start1;
  int          cur_sel;

  logic        in_valid0, in_valid1;
  logic        in_ready0, in_ready1;
  logic        mem_we0, mem_we1;
  logic [7:0]  mem_addr0, mem_addr1;
  logic [31:0] mem_din0, mem_din1;
  logic        busy0, busy1, done0, done1, err0, err1, cpu_rst_n0, cpu_rst_n1;
  logic        s_ready, s_busy, s_done, s_err, s_cpu;

  int  tests = 0;
  int  fails = 0;
  wr_t q0[$];
  wr_t q1[$];
  load_vec_t vecs[5];

  always #5 clk = ~clk;

  assign in_valid0 = in_valid && (cur_sel == 0);
  assign in_valid1 = in_valid && (cur_sel == 1);
  assign s_ready   = (cur_sel == 1) ? in_ready1  : in_ready0;
  assign s_busy    = (cur_sel == 1) ? busy1      : busy0;
  assign s_done    = (cur_sel == 1) ? done1      : done0;
  assign s_err     = (cur_sel == 1) ? err1       : err0;
  assign s_cpu     = (cur_sel == 1) ? cpu_rst_n1 : cpu_rst_n0;

  program_loader #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(8'h00)) dut0 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start0), .in_valid(in_valid0),
    .in_byte(in_byte), .in_ready(in_ready0), .mem_we(mem_we0), .mem_addr(mem_addr0),
    .mem_din(mem_din0), .busy(busy0), .done(done0), .err(err0), .cpu_rst_n(cpu_rst_n0)
  );

  program_loader #(.ADDR_W(8), .DATA_W(32), .BASE_ADDR(8'hFE)) dut1 (
    .clk(clk), .rst_n(rst_n), .load_start(load_start1), .in_valid(in_valid1),
    .in_byte(in_byte), .in_ready(in_ready1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_din(mem_din1), .busy(busy1), .done(done1), .err(err1), .cpu_rst_n(cpu_rst_n1)
  );

  function automatic void checkOutput(input string name, input logic [31:0] act,
                                      input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endfunction

  function automatic logic [31:0] word_of(input load_vec_t v, input int i);
    if (i == 0) return v.w0;
    if (i == 1) return v.w1;
    return v.w1 + 32'(i) * 32'h01020304;
  endfunction

  // Scoreboard: every write must match the next queued expectation, and
  // the stream must be stalled (in_ready low) while writing.
  always @(negedge clk) begin
    if (mem_we0) begin
      if (q0.size() == 0) begin
        checkOutput("dut0_unexpected_write_addr", {24'h0, mem_addr0}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = q0.pop_front();
        checkOutput("dut0_write_addr", {24'h0, mem_addr0}, {24'h0, e.addr});
        checkOutput("dut0_write_data", mem_din0, e.data);
        checkOutput("dut0_ready_in_write", {31'h0, in_ready0}, 32'h0);
      end
    end
    if (mem_we1) begin
      if (q1.size() == 0) begin
        checkOutput("dut1_unexpected_write_addr", {24'h0, mem_addr1}, 32'hFFFF_FFFF);
      end else begin
        wr_t e;
        e = q1.pop_front();
        checkOutput("dut1_write_addr", {24'h0, mem_addr1}, {24'h0, e.addr});
        checkOutput("dut1_write_data", mem_din1, e.data);
        checkOutput("dut1_ready_in_write", {31'h0, in_ready1}, 32'h0);
      end
    end
  end

  task automatic checkReset(input string tag);
    checkOutput({tag, "_in_ready"},  {31'h0, in_ready0},  32'h0);
    checkOutput({tag, "_mem_we"},    {31'h0, mem_we0},    32'h0);
    checkOutput({tag, "_mem_addr0"}, {24'h0, mem_addr0},  32'h00);
    checkOutput({tag, "_mem_addr1"}, {24'h0, mem_addr1},  32'hFE);
    checkOutput({tag, "_mem_din"},   mem_din0,            32'h0);
    checkOutput({tag, "_busy"},      {31'h0, busy0},      32'h0);
    checkOutput({tag, "_done"},      {31'h0, done0},      32'h0);
    checkOutput({tag, "_err"},       {31'h0, err0},       32'h0);
    checkOutput({tag, "_cpu_rst_n0"},{31'h0, cpu_rst_n0}, 32'h0);
    checkOutput({tag, "_cpu_rst_n1"},{31'h0, cpu_rst_n1}, 32'h0);
  endtask

  // Offers one byte until it is taken; optional random idle gaps first.
  task automatic sendByte(input logic [7:0] b, input bit stall, input bit poke);
    bit   sent;
    int   guard;
    logic rdy;
    sent  = 1'b0;
    guard = 0;
    if (stall) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        in_valid    = 1'b0;
        load_start0 = 1'b0;
        load_start1 = 1'b0;
      end
    end
    while (!sent && guard < 40) begin
      @(negedge clk);
      in_valid    = 1'b1;
      in_byte     = b;
      load_start0 = poke && (cur_sel == 0);
      load_start1 = poke && (cur_sel == 1);
      rdy         = s_ready;
      @(posedge clk);
      sent = rdy;
      guard++;
    end
    if (!sent) begin
      tests++;
      fails++;
      $display("[TB] FAIL byte_accept: in_ready stayed 0, expected 1 for byte %h", b);
    end
  endtask

  task automatic startLoad(input int sel);
    cur_sel = sel;
    @(negedge clk);
    in_valid    = 1'b0;
    load_start0 = (sel == 0);
    load_start1 = (sel == 1);
    @(negedge clk);
    load_start0 = 1'b0;
    load_start1 = 1'b0;
    checkOutput("len_busy",      {31'h0, s_busy},  32'h1);
    checkOutput("len_cpu_rst_n", {31'h0, s_cpu},   32'h0);
    checkOutput("len_err",       {31'h0, s_err},   32'h0);
    checkOutput("len_in_ready",  {31'h0, s_ready}, 32'h1);
  endtask

  task automatic applyStimulus(input load_vec_t v, input bit bad_chk);
    int          nw;
    int          lat;
    int          exp_lat;
    bit          seen_done;
    logic [7:0]  cs;
    logic [7:0]  base;
    logic [31:0] w;
    wr_t         e;
    nw   = (v.n_byte == 8'd0) ? 256 : int'(v.n_byte);
    cs   = 8'h00;
    base = (v.sel == 1) ? 8'hFE : 8'h00;
    startLoad(v.sel);
    for (int i = 0; i < nw; i++) begin
      e.addr = base + 8'(i);
      e.data = word_of(v, i);
      if (v.sel == 1) q1.push_back(e);
      else q0.push_back(e);
    end
    sendByte(v.n_byte, v.stall, 1'b0);
    for (int i = 0; i < nw; i++) begin
      w = word_of(v, i);
      for (int b = 0; b < 4; b++) begin
        cs = cs ^ w[31-8*b -: 8];
        sendByte(w[31-8*b -: 8], v.stall, v.poke && (i == 0) && (b == 1));
      end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    sendByte(bad_chk ? (cs ^ 8'h01) : cs, v.stall, 1'b0);
    exp_lat = 1;
`else
    exp_lat = 2;
`endif
    if (!bad_chk) begin
      lat = 0;
      do begin
        @(negedge clk);
        in_valid = 1'b0;
        lat++;
      end while (!s_done && lat < 8);
      checkOutput("done_latency",    32'(lat),         32'(exp_lat));
      checkOutput("done_busy",       {31'h0, s_busy},  32'h0);
      checkOutput("done_cpu_rst_n",  {31'h0, s_cpu},   32'h1);
      checkOutput("done_err",        {31'h0, s_err},   32'h0);
      @(negedge clk);
      checkOutput("after_done_pulse",     {31'h0, s_done}, 32'h0);
      checkOutput("after_done_cpu_rst_n", {31'h0, s_cpu},  32'h1);
    end else begin
      @(negedge clk);
      in_valid  = 1'b0;
      seen_done = s_done;
      checkOutput("chk_bad_err",       {31'h0, s_err},  32'h1);
      checkOutput("chk_bad_busy",      {31'h0, s_busy}, 32'h0);
      checkOutput("chk_bad_cpu_rst_n", {31'h0, s_cpu},  32'h0);
      repeat (3) begin
        @(negedge clk);
        seen_done = seen_done | s_done;
      end
      checkOutput("chk_bad_no_done", {31'h0, seen_done}, 32'h0);
      checkOutput("chk_bad_err_sticky", {31'h0, s_err}, 32'h1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    load_vec_t mid;
    wr_t       e;
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    in_byte     = 8'h00;
    load_start0 = 1'b0;
    load_start1 = 1'b0;
    cur_sel     = 0;

    vecs[0] = '{sel: 0, n_byte: 8'h02, w0: 32'h20080005, w1: 32'hAC010004, stall: 1'b0, poke: 1'b0};
    vecs[1] = '{sel: 0, n_byte: 8'h02, w0: 32'h20080005, w1: 32'hAC010004, stall: 1'b1, poke: 1'b0};
    vecs[2] = '{sel: 0, n_byte: 8'h03, w0: 32'hDEADBEEF, w1: 32'h01234567, stall: 1'b1, poke: 1'b1};
    vecs[3] = '{sel: 1, n_byte: 8'h00, w0: 32'hCAFEF00D, w1: 32'h00000001, stall: 1'b0, poke: 1'b0};
    vecs[4] = '{sel: 0, n_byte: 8'h01, w0: 32'h12345678, w1: 32'h0,        stall: 1'b0, poke: 1'b0};

    repeat (2) @(negedge clk);
    checkReset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("idle_cpu_held", {31'h0, cpu_rst_n0}, 32'h0);

    $display("[TB] table-driven loads");
    for (int k = 0; k < 5; k++) applyStimulus(vecs[k], 1'b0);

    $display("[TB] mid-load reset");
    mid = '{sel: 0, n_byte: 8'h04, w0: 32'h11223344, w1: 32'h55667788, stall: 1'b0, poke: 1'b0};
    startLoad(0);
    for (int i = 0; i < 2; i++) begin
      e.addr = 8'(i);
      e.data = word_of(mid, i);
      q0.push_back(e);
    end
    sendByte(mid.n_byte, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < 4; b++) sendByte(word_of(mid, i) >> (24 - 8*b), 1'b0, 1'b0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("pre_reset_busy", {31'h0, busy0}, 32'h1);
    checkOutput("pre_reset_writes_left", 32'(q0.size()), 32'h0);
    rst_n = 1'b0;
    #1;
    checkReset("mid_reset");
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(vecs[0], 1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
    $display("[TB] checksum mismatch");
    applyStimulus(vecs[4], 1'b1);
    applyStimulus(vecs[4], 1'b0);
`endif

    repeat (3) @(negedge clk);
    checkOutput("queue0_drained", 32'(q0.size()), 32'h0);
    checkOutput("queue1_drained", 32'(q1.size()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
